alu_issue: RTL and testbench
============================

# alu_issue

Issue/execute front-end that sits directly upstream of the ALU. It accepts 16-bit register-register instructions over a valid/ready handshake and reads two operands from an internal 8×32 register file. It presents opcode and operands to the ALU, waits for `alu_done`, then writes the result back and returns it on a result handshake. A host write port preloads registers.

## Interface
- `NREGS`, default 8: register count; fixed at 8 because the instruction fields are 3 bits.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `instr_valid`  in  1: instruction offered.
- `instr_ready`  out  1: block can accept an instruction.
- `instr`  in  16: instruction fields are `[15:12]` op (`opcode_t`), `[11:9]` rd, `[8:6]` rs1, `[5:3]` rs2, `[2:0]` ignored.
- `host_wr_en`  in  1: host register write strobe.
- `host_wr_addr`  in  3: host write index.
- `host_wr_data`  in  32: host write data.
- `alu_op`  out  4: to ALU `alu_op`.
- `alu_a`  out  32: to ALU `alu_a` (rs1 value).
- `alu_b`  out  32: to ALU `alu_b` (rs2 value).
- `alu_result`  in  32: from ALU.
- `alu_done`  in  1: from ALU; result is valid when high.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `res_data`  out  32: captured ALU result.
- `res_rd`  out  3: destination index of the completed instruction.
- `res_err`  out  1: completed instruction was RES1/RES2.
- `busy`  out  1: state is not IDLE.

## Operation
- FSM states:
  - IDLE: `instr_ready`=1. When `instr_valid` is high, latch op and rd, and read rs1/rs2 from the register file into operand registers → EXEC.
  - EXEC: drive `alu_op`/`alu_a`/`alu_b` from the latched registers. If `alu_done`=1, capture `alu_result` into `res_data` and perform writeback → RESP. If `alu_done`=0, stay in EXEC with inputs held stable.
  - RESP: `res_valid`=1. When `res_ready` is high → IDLE.
- Writeback rules:
  - Every op except NOP, RES1 and RES2 writes `alu_result` to rd.
  - NOP completes with `res_data`=0 and no write.
  - RES1/RES2 set `res_err`=1, write nothing, and `res_data` is the captured ALU output (0).
- Arithmetic is 32-bit two's-complement, truncated by the ALU. This block never extends or modifies results.
- Register file reads are combinational in the IDLE accept cycle and return pre-edge contents (read-before-write).
- Host write port:
  - Active in every state.
  - If a host write and a writeback target the same register on the same edge, writeback wins.
  - A host write to rs1/rs2 on the accept edge is not seen by that instruction.
- `alu_op`/`alu_a`/`alu_b` are driven only in EXEC; in all other states they are 0.
- Reset mid-operation abandons the in-flight instruction with no writeback, and clears the register file to 0.

## Timing
- Reset values: `instr_ready`=1, `res_valid`=0, `res_data`=0, `res_rd`=0, `res_err`=0, `busy`=0, `alu_op`/`alu_a`/`alu_b`=0, all registers 0, state IDLE.
- Accept happens at edge N. With `alu_done`=1, EXEC is cycle N+1, and writeback plus `res_*` capture occur at edge N+2. `res_valid` is high from cycle N+2.
- Each cycle of `alu_done`=0 adds one cycle of latency.
- Maximum throughput is one instruction per 3 cycles. `instr_ready` is high only in IDLE; there is no overlap.
- `res_data`, `res_rd` and `res_err` stay stable while `res_valid`=1 and `res_ready`=0. They hold their last values after the handshake.
- A result written to rd is visible to an instruction accepted on any later edge.

## Configuration
- `ALU_ISSUE_R0_ZERO_EN`:
  - Defined: register 0 always reads 0. Writes to r0 from both writeback and the host port are discarded. The result is still reported on `res_data` with `res_rd`=0.
  - Undefined: r0 is an ordinary register.

## Structure
- `opcode_pkg`:
  - Already supplies `opcode_t`.
  - Add `instr_t`, a packed struct with op/rd/rs1/rs2/pad fields.
  - Add localparams for the field widths (`OP_W`=4, `REG_IDX_W`=3).
- The FSM state enum is local to `alu_issue`.
- One sub-module, `alu_regfile`: 8×32, two combinational read ports, writeback port plus host write port with writeback priority. The `ALU_ISSUE_R0_ZERO_EN` logic lives here.

## Test plan
- Host writes r1=7 and r2=5, then ADD r3,r1,r2 with `res_ready`=1 → `res_valid` at N+2, `res_data`=12, `res_rd`=3. A following ADD r4,r3,r0 (r0=0) → 12.
- SUB r4,r2,r1 → `res_data`=0xFFFFFFFE. SP2 with r1=3, r2=5 → 57. LSL with r1=0x80000001 → 0x00000002.
- RES1 r5,r1,r2 → `res_err`=1, `res_data`=0. A later ADD r6,r5,r0 returns 0 (r5 unwritten).
- Hold `alu_done` low 3 cycles in EXEC → `alu_*` stable, `res_valid` first at N+5. Hold `res_ready` low 4 cycles → `res_*` stable, `instr_ready`=0 throughout.
- Host write r3=0xAAAA5555 on the same edge as a writeback to r3 of 9 → r3=9. Assert `rst` in EXEC → no writeback, all registers 0, outputs at reset values.
- With `ALU_ISSUE_R0_ZERO_EN`: host write r0=5, then ADD r0,r0,r0 → `res_data`=0, and r0 still reads 0.

Source files
------------

// File: rtl/opcode_pkg.sv
// Shared opcode encoding, instruction layout and field widths for the ALU
// issue front-end.
package opcode_pkg;

  localparam int unsigned OP_W      = 4;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LSL  = 4'h6,
    OP_LSR  = 4'h7,
    OP_ASR  = 4'h8,
    OP_SLT  = 4'h9,
    OP_SLTU = 4'hA,
    OP_MUL  = 4'hB,
    OP_SP1  = 4'hC,
    OP_SP2  = 4'hD,
    OP_RES1 = 4'hE,
    OP_RES2 = 4'hF
  } opcode_t;

  typedef struct packed {
    opcode_t              op;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [2:0]           pad;
  } instr_t;

  // Reserved opcodes and NOP never touch the register file.
  function automatic logic op_writes_rd(opcode_t op);
    return !(op == OP_NOP || op == OP_RES1 || op == OP_RES2);
  endfunction

  function automatic logic op_is_reserved(opcode_t op);
    return (op == OP_RES1 || op == OP_RES2);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x32 register file: two combinational read ports, a writeback port and a
// host write port. Writeback wins over the host port on the same register.
// Optional: ALU_ISSUE_R0_ZERO_EN hardwires r0 to zero.
module alu_regfile
  import opcode_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]    rd_data_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_b,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 host_en,
  input  logic [REG_IDX_W-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next register contents: host write first, writeback applied over it.
  always_comb begin
    regs_d = regs_q;
    if (host_en) regs_d[host_addr] = host_data;
    if (wb_en)   regs_d[wb_addr]   = wb_data;
`ifdef ALU_ISSUE_R0_ZERO_EN
    regs_d[0] = '0;
`endif
  end

  // Register storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports return pre-edge contents.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/execute front-end ahead of the ALU: accepts an instruction, reads
// operands, waits for alu_done, writes back and returns the result.
// Optional: ALU_ISSUE_R0_ZERO_EN (r0 hardwired to zero, in alu_regfile).
module alu_issue
  import opcode_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [15:0]          instr,
  input  logic                 host_wr_en,
  input  logic [REG_IDX_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0]    host_wr_data,
  output logic [OP_W-1:0]      alu_op,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic [REG_IDX_W-1:0] res_rd,
  output logic                 res_err,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t               state_q, state_d;
  opcode_t              op_q, op_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]    res_data_q, res_data_d;
  logic [REG_IDX_W-1:0] res_rd_q, res_rd_d;
  logic                 res_err_q, res_err_d;

  instr_t               ins;
  logic [DATA_W-1:0]    rf_a, rf_b;
  logic                 wb_en;

  assign ins   = instr_t'(instr);
  assign wb_en = (state_q == S_EXEC) && alu_done && op_writes_rd(op_q);

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (ins.rs1),
    .rd_data_a (rf_a),
    .rd_addr_b (ins.rs2),
    .rd_data_b (rf_b),
    .wb_en     (wb_en),
    .wb_addr   (rd_q),
    .wb_data   (alu_result),
    .host_en   (host_wr_en),
    .host_addr (host_wr_addr),
    .host_data (host_wr_data)
  );

  // Next-state and datapath capture for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    res_err_d  = res_err_q;
    unique case (state_q)
      S_IDLE: if (instr_valid) begin
        op_d    = ins.op;
        rd_d    = ins.rd;
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = S_EXEC;
      end
      S_EXEC: if (alu_done) begin
        res_data_d = (op_q == OP_NOP) ? '0 : alu_result;
        res_rd_d   = rd_q;
        res_err_d  = op_is_reserved(op_q);
        state_d    = S_RESP;
      end
      S_RESP: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      res_err_q  <= res_err_d;
    end
  end

  // Outputs decoded from the registered state; ALU inputs are zero outside EXEC.
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    res_valid   = (state_q == S_RESP);
    alu_op      = (state_q == S_EXEC) ? op_q : '0;
    alu_a       = (state_q == S_EXEC) ? a_q  : '0;
    alu_b       = (state_q == S_EXEC) ? b_q  : '0;
    res_data    = res_data_q;
    res_rd      = res_rd_q;
    res_err     = res_err_q;
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed, table-driven bench for alu_issue. The bench plays the ALU: each
// vector supplies the result the ALU returns and the expected block outputs.
module tb_alu_issue;
  import opcode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        host_wr_en;
  logic [2:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_done;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_rd;
  logic        res_err, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue #(.NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_done(alu_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_err(res_err), .busy(busy)
  );

  typedef struct {
    logic        hen;
    logic [2:0]  haddr;
    logic [31:0] hdata;
    opcode_t     op;
    logic [2:0]  rd, rs1, rs2;
    int          hold;
    int          rhold;
    logic [31:0] ea, eb, ares, edata;
    logic        eerr;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
    host_wr_en = 1'b1; host_wr_addr = addr; host_wr_data = data;
    @(posedge clk); #1;
    host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr_ready"}, {31'b0, instr_ready}, 32'd1);
    chk({tag, "_res_valid"},   {31'b0, res_valid},   32'd0);
    chk({tag, "_res_data"},    res_data,             32'd0);
    chk({tag, "_res_rd"},      {29'b0, res_rd},      32'd0);
    chk({tag, "_res_err"},     {31'b0, res_err},     32'd0);
    chk({tag, "_busy"},        {31'b0, busy},        32'd0);
    chk({tag, "_alu_op"},      {28'b0, alu_op},      32'd0);
    chk({tag, "_alu_a"},       alu_a,                32'd0);
    chk({tag, "_alu_b"},       alu_b,                32'd0);
  endtask

  // Full instruction: accept, EXEC (with optional alu_done stall), RESP
  // (with optional res_ready stall). Optionally collides a host write with
  // the writeback edge.
  task automatic run_instr(input opcode_t op, input logic [2:0] rd, rs1, rs2,
                           input int hold, rhold,
                           input logic [31:0] ea, eb, ares, edata,
                           input logic eerr, input logic coll,
                           input logic [31:0] cdata);
    chk("idle_ready", {31'b0, instr_ready}, 32'd1);
    instr = {op, rd, rs1, rs2, 3'b000};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = '0;
    chk("exec_busy",   {31'b0, busy},        32'd1);
    chk("exec_ready",  {31'b0, instr_ready}, 32'd0);
    chk("exec_alu_op", {28'b0, alu_op},      {28'b0, op});
    chk("exec_alu_a",  alu_a, ea);
    chk("exec_alu_b",  alu_b, eb);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("stall_alu_a",     alu_a, ea);
      chk("stall_alu_b",     alu_b, eb);
      chk("stall_alu_op",    {28'b0, alu_op}, {28'b0, op});
      chk("stall_res_valid", {31'b0, res_valid}, 32'd0);
    end
    alu_done = 1'b1; alu_result = ares;
    if (coll) begin
      host_wr_en = 1'b1; host_wr_addr = rd; host_wr_data = cdata;
    end
    @(posedge clk); #1;
    alu_done = 1'b0; alu_result = '0;
    host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    chk("resp_valid", {31'b0, res_valid}, 32'd1);
    chk("resp_data",  res_data, edata);
    chk("resp_rd",    {29'b0, res_rd},  {29'b0, rd});
    chk("resp_err",   {31'b0, res_err}, {31'b0, eerr});
    chk("resp_alu_a", alu_a, 32'd0);
    for (int r = 0; r < rhold; r++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, res_valid},   32'd1);
      chk("hold_data",  res_data, edata);
      chk("hold_rd",    {29'b0, res_rd},      {29'b0, rd});
      chk("hold_err",   {31'b0, res_err},     {31'b0, eerr});
      chk("hold_ready", {31'b0, instr_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("done_valid", {31'b0, res_valid}, 32'd0);
    chk("done_data",  res_data, edata);
  endtask

  initial begin
    //           hen   haddr data          op       rd    rs1   rs2  hold rh  ea            eb            ares          edata         err
    vec[0]  = '{1'b1, 3'd1, 32'd7,        OP_ADD,  3'd3, 3'd1, 3'd2, 0, 0, 32'd7,        32'd5,        32'd12,       32'd12,       1'b0};
    vec[1]  = '{1'b0, 3'd0, 32'd0,        OP_ADD,  3'd4, 3'd3, 3'd0, 0, 0, 32'd12,       32'd0,        32'd12,       32'd12,       1'b0};
    vec[2]  = '{1'b0, 3'd0, 32'd0,        OP_SUB,  3'd4, 3'd2, 3'd1, 0, 0, 32'd5,        32'd7,        32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
    vec[3]  = '{1'b1, 3'd1, 32'd3,        OP_SP2,  3'd7, 3'd1, 3'd2, 0, 0, 32'd3,        32'd5,        32'd57,       32'd57,       1'b0};
    vec[4]  = '{1'b1, 3'd2, 32'd1,        OP_NOP,  3'd0, 3'd0, 3'd0, 0, 0, 32'd0,        32'd0,        32'h1234,     32'd0,        1'b0};
    vec[5]  = '{1'b1, 3'd1, 32'h80000001, OP_LSL,  3'd6, 3'd1, 3'd2, 0, 0, 32'h80000001, 32'd1,        32'd2,        32'd2,        1'b0};
    vec[6]  = '{1'b0, 3'd0, 32'd0,        OP_RES1, 3'd5, 3'd1, 3'd2, 0, 0, 32'h80000001, 32'd1,        32'd0,        32'd0,        1'b1};
    vec[7]  = '{1'b0, 3'd0, 32'd0,        OP_ADD,  3'd6, 3'd5, 3'd0, 0, 0, 32'd0,        32'd0,        32'd0,        32'd0,        1'b0};
    vec[8]  = '{1'b0, 3'd0, 32'd0,        OP_ADD,  3'd1, 3'd7, 3'd0, 3, 4, 32'd57,       32'd0,        32'd57,       32'd57,       1'b0};
    vec[9]  = '{1'b0, 3'd0, 32'd0,        OP_RES2, 3'd2, 3'd3, 3'd4, 0, 0, 32'd12,       32'hFFFFFFFE, 32'd0,        32'd0,        1'b1};
    vec[10] = '{1'b0, 3'd0, 32'd0,        OP_SUB,  3'd3, 3'd2, 3'd1, 0, 0, 32'd1,        32'd57,       32'hFFFFFFC8, 32'hFFFFFFC8, 1'b0};

    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    alu_result = '0; alu_done = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("rst");

    host_write(3'd2, 32'd5);
    for (int i = 0; i < 11; i++) begin
      if (vec[i].hen) host_write(vec[i].haddr, vec[i].hdata);
      run_instr(vec[i].op, vec[i].rd, vec[i].rs1, vec[i].rs2, vec[i].hold,
                vec[i].rhold, vec[i].ea, vec[i].eb, vec[i].ares, vec[i].edata,
                vec[i].eerr, 1'b0, 32'd0);
    end

    // Host write and writeback to r3 on the same edge: writeback wins.
    run_instr(OP_ADD, 3'd3, 3'd6, 3'd7, 0, 0, 32'd0, 32'd57, 32'd9, 32'd9,
              1'b0, 1'b1, 32'hAAAA5555);
    run_instr(OP_ADD, 3'd4, 3'd3, 3'd0, 0, 0, 32'd9, 32'd0, 32'd9, 32'd9,
              1'b0, 1'b0, 32'd0);

    // Reset during EXEC with alu_done high: nothing written, regs cleared.
    instr = {OP_ADD, 3'd3, 3'd1, 3'd2, 3'b000};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = '0;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1; alu_done = 1'b1; alu_result = 32'h55;
    @(posedge clk); #1;
    rst = 1'b0; alu_done = 1'b0; alu_result = '0;
    chk_reset_outputs("midrst");
    run_instr(OP_ADD, 3'd5, 3'd1, 3'd2, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 32'd0);
    run_instr(OP_ADD, 3'd6, 3'd3, 3'd4, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 32'd0);
    run_instr(OP_ADD, 3'd7, 3'd7, 3'd6, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 32'd0);

`ifdef ALU_ISSUE_R0_ZERO_EN
    host_write(3'd0, 32'd5);
    run_instr(OP_ADD, 3'd0, 3'd0, 3'd0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 32'd0);
    run_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
